// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, instruction field widths, NOP word and fetch FSM encoding.
package mips_pkg;

  localparam int XLEN     = 32;
  localparam int OPCODE_W = 6;
  localparam int REG_W    = 5;
  localparam int SHAMT_W  = 5;
  localparam int FUNCT_W  = 6;
  localparam int IMM_W    = 16;
  localparam int JADDR_W  = 26;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'd0;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'd2;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'd4;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'd5;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'd8;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'd35;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'd43;

  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_FULL = 2'd2
  } fetch_state_e;

  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/ifu_pc_ctl.sv
// PC, pending-redirect target and squash flag for the fetch stage; redirect always wins.
// IFETCH_ALIGN_EXC_EN keeps target[1:0] and allows the exception-vector load; otherwise PCs are word-aligned.
module ifu_pc_ctl
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [XLEN-1:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_active_i,
  input  logic            ack_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] target_i,
`ifdef IFETCH_ALIGN_EXC_EN
  input  logic            exc_take_i,
`endif
  output logic [XLEN-1:0] pc_o,
  output logic            squash_o
);

  logic [XLEN-1:0] pc_q, pc_d, pc_next_q, pc_next_d, tgt;
  logic            squash_q, squash_d;

`ifdef IFETCH_ALIGN_EXC_EN
  assign tgt = target_i;
`else
  logic unused_tgt_lo;
  assign tgt           = {target_i[XLEN-1:2], 2'b00};
  assign unused_tgt_lo = ^target_i[1:0];
`endif

  always_comb begin
    pc_d      = pc_q;
    pc_next_d = pc_next_q;
    squash_d  = squash_q;
    if (redirect_i) begin
      // An issued request cannot be withdrawn: park the target until its ack retires it.
      if (req_active_i && !ack_i) begin
        squash_d  = 1'b1;
        pc_next_d = tgt;
      end else begin
        pc_d     = tgt;
        squash_d = 1'b0;
      end
    end else if (req_active_i && ack_i) begin
      squash_d = 1'b0;
      pc_d     = squash_q ? pc_next_q : pc_plus4(pc_q);
    end
`ifdef IFETCH_ALIGN_EXC_EN
    else if (exc_take_i) begin
      pc_d = EXC_VECTOR;
    end
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q      <= RESET_PC;
      pc_next_q <= RESET_PC;
      squash_q  <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      pc_next_q <= pc_next_d;
      squash_q  <= squash_d;
    end
  end

  assign pc_o     = pc_q;
  assign squash_o = squash_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// MIPS fetch stage: fetch FSM, req/ack to instruction memory and one-entry IR feeding decode.
// IFETCH_ALIGN_EXC_EN turns misaligned PCs into a fetch-exception IR entry instead of masking them.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [XLEN-1:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [XLEN-1:0]     imem_addr,
  input  logic                imem_ack,
  input  logic [XLEN-1:0]     imem_rdata,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_target,
  output logic                dec_valid,
  input  logic                dec_ready,
  output logic [XLEN-1:0]     dec_instr,
  output logic [OPCODE_W-1:0] dec_opcode,
`ifdef IFETCH_ALIGN_EXC_EN
  output logic [XLEN-1:0]     dec_pc4,
  output logic                dec_exc,
  output logic [XLEN-1:0]     dec_badaddr
`else
  output logic [XLEN-1:0]     dec_pc4
`endif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc, ir_q, pc4_q;
  logic            squash, misaligned, req_active, accept, exc_take, consume, valid_q;

`ifdef IFETCH_ALIGN_EXC_EN
  logic            exc_q;
  logic [XLEN-1:0] badaddr_q;
  assign misaligned  = (pc[1:0] != 2'b00);
  assign dec_exc     = exc_q;
  assign dec_badaddr = badaddr_q;
`else
  assign misaligned = 1'b0;
`endif

  assign req_active = (state_q == FETCH_REQ) && !misaligned;
  assign accept     = req_active && imem_ack && !squash && !redirect_valid;
  assign exc_take   = (state_q == FETCH_REQ) && misaligned && !redirect_valid;
  assign consume    = (state_q == FETCH_FULL) && (redirect_valid || dec_ready);

  ifu_pc_ctl #(.RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VECTOR)) u_pc_ctl (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_active_i (req_active),
    .ack_i        (imem_ack),
    .redirect_i   (redirect_valid),
    .target_i     (redirect_target),
`ifdef IFETCH_ALIGN_EXC_EN
    .exc_take_i   (exc_take),
`endif
    .pc_o         (pc),
    .squash_o     (squash)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH_IDLE: state_d = FETCH_REQ;
      FETCH_REQ:  if (accept || exc_take) state_d = FETCH_FULL;
      FETCH_FULL: if (consume) state_d = FETCH_REQ;
      default:    state_d = FETCH_IDLE;
    endcase
  end

  always_comb begin
    imem_req  = req_active;
    imem_addr = req_active ? pc : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      ir_q      <= NOP_WORD;
      pc4_q     <= '0;
`ifdef IFETCH_ALIGN_EXC_EN
      exc_q     <= 1'b0;
      badaddr_q <= '0;
`endif
    end else if (accept) begin
      valid_q <= 1'b1;
      ir_q    <= imem_rdata;
      pc4_q   <= pc_plus4(pc);
    end else if (exc_take) begin
      valid_q   <= 1'b1;
      ir_q      <= NOP_WORD;
`ifdef IFETCH_ALIGN_EXC_EN
      exc_q     <= 1'b1;
      badaddr_q <= pc;
`endif
    end else if (consume) begin
      valid_q <= 1'b0;
`ifdef IFETCH_ALIGN_EXC_EN
      exc_q   <= 1'b0;
`endif
    end
  end

  assign dec_valid  = valid_q;
  assign dec_instr  = ir_q;
  assign dec_opcode = ir_q[XLEN-1 -: OPCODE_W];
  assign dec_pc4    = pc4_q;

endmodule
